// File: rtl/ripple_count_capture_display.sv
// Ripple counter capture and display.
// Brings the 4-bit asynchronous ripple counter into the clk domain, filters
// out ripple transients, counts 15->0 wraps, and scans both values onto a
// two-digit multiplexed 7-segment display.
module ripple_count_capture_display #(
  parameter int STABLE_CYCLES  = 2,
  parameter int REFRESH_W      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  output logic [3:0] cnt_stable,
  output logic       cnt_upd,
  output logic       wrap_pulse,
  output logic [3:0] wrap_count,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int SW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'ha: hex7 = 7'b1110111;
      4'hb: hex7 = 7'b1111100;
      4'hc: hex7 = 7'b0111001;
      4'hd: hex7 = 7'b1011110;
      4'he: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    seg_pol = SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [1:0] an_pol(input logic [1:0] a);
    an_pol = SEG_ACTIVE_LOW ? ~a : a;
  endfunction

  logic [3:0]           s1, s2, s3;
  logic [SW-1:0]        stab_cnt, stab_nxt;
  logic                 accept, is_wrap;
  logic [REFRESH_W-1:0] refresh;
  logic                 digit_sel, dsel_nxt;

  // Acceptance looks at the count this edge will produce, so a value held
  // STABLE_CYCLES+1 cycles lands exactly STABLE_CYCLES+2 edges after capture.
  always_comb begin
    stab_nxt = '0;
    if (s2 == s3) stab_nxt = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + SW'(1);
    accept   = (stab_nxt == STAB_MAX) && (s2 != cnt_stable);
    is_wrap  = (cnt_stable == 4'hf) && (s2 == 4'h0);
    dsel_nxt = (&refresh) ? ~digit_sel : digit_sel;
  end

  // Two-flop synchronizer plus one previous-sample stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Stability filter, accepted value, update/wrap pulses and wrap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt   <= '0;
      cnt_stable <= '0;
      cnt_upd    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      stab_cnt   <= stab_nxt;
      cnt_upd    <= accept;
      wrap_pulse <= accept && is_wrap;
      if (accept) cnt_stable <= s2;
      if (accept && is_wrap) wrap_count <= wrap_count + 4'd1;
    end
  end

  // Display scan: digit select, enables and segments all change on one edge
  // so a digit never shows the other digit's pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh   <= '0;
      digit_sel <= 1'b0;
      an        <= an_pol(2'b01);
      seg       <= seg_pol(hex7(4'h0));
    end else begin
      refresh   <= refresh + REFRESH_W'(1);
      digit_sel <= dsel_nxt;
      an        <= an_pol(dsel_nxt ? 2'b10 : 2'b01);
      seg       <= seg_pol(hex7(dsel_nxt ? wrap_count : cnt_stable));
    end
  end

endmodule

// File: tb/tb_ripple_count_capture_display.sv
// Bench for ripple_count_capture_display: directed stimulus pushes expected
// acceptances into a queue; a monitor pops one entry per cnt_upd pulse.
module tb_ripple_count_capture_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic [3:0] cnt_stable, wrap_count;
  logic       cnt_upd, wrap_pulse;
  logic [6:0] seg;
  logic [1:0] an;

  ripple_count_capture_display #(.STABLE_CYCLES(2), .REFRESH_W(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_stable(cnt_stable), .cnt_upd(cnt_upd),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic       w;
    logic [3:0] wc;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [3:0] wc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cnt_upd pulse must match the next expected acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (cnt_upd) begin
        if (q.size() == 0) begin
          check("unexpected_upd", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("cnt_stable", cnt_stable, e.v);
          check("wrap_pulse", wrap_pulse, e.w);
          check("wrap_count", wrap_count, e.wc);
          check("upd_edge", cyc, e.cyc);
        end
      end else if (wrap_pulse) begin
        check("wrap_without_upd", 1, 0);
      end
    end
  end

  // Called at a negedge; value is captured by the next posedge and held for
  // 'hold' edges. An accepted value appears 4 edges after capture.
  task automatic drive(input logic [3:0] v, input int hold, input bit push,
                       input logic w, input logic [3:0] ewc);
    exp_t e;
    cnt_in = v;
    if (push) begin
      e.v = v; e.w = w; e.wc = ewc; e.cyc = cyc + 5;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);
  endtask

  task automatic wait_an_change(output int t);
    logic [1:0] a0;
    int n = 0;
    a0 = an;
    while (an == a0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("an_toggle_seen", int'(an != a0), 1);
    t = cyc;
  endtask

  initial begin
    int t0, t1, t2;
    rst = 1'b1;
    cnt_in = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_cnt_stable", cnt_stable, 0);
    check("rst_cnt_upd", cnt_upd, 0);
    check("rst_wrap_pulse", wrap_pulse, 0);
    check("rst_wrap_count", wrap_count, 0);
    check("rst_an", an, 2'b10);
    check("rst_seg", seg, 7'b1000000);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_cnt_stable", cnt_stable, 0);

    // 0 -> 1
    drive(4'h1, 6, 1, 1'b0, 4'h0);
    drain();

    // 15, ripple 1110/1100/1000 one cycle each, then 0 -> one wrap
    drive(4'hf, 6, 1, 1'b0, 4'h0);
    drive(4'he, 1, 0, 1'b0, 4'h0);
    drive(4'hc, 1, 0, 1'b0, 4'h0);
    drive(4'h8, 1, 0, 1'b0, 4'h0);
    drive(4'h0, 6, 1, 1'b1, 4'h1);
    drain();
    check("wc_after_ripple", wrap_count, 1);

    // 16 full cycles: wrap_count comes back to 1
    wc = 4'h1;
    for (int r = 0; r < 16; r++) begin
      for (int v = 1; v < 16; v++) drive(4'(v), 4, 1, 1'b0, wc);
      wc = wc + 4'd1;
      drive(4'h0, 4, 1, 1'b1, wc);
    end
    drain();
    check("wc_after_16", wrap_count, 1);

    // two more wraps -> 3, then 5 -> 0 counter reset is not a wrap
    drive(4'hf, 6, 1, 1'b0, 4'h1);
    drive(4'h0, 6, 1, 1'b1, 4'h2);
    drive(4'hf, 6, 1, 1'b0, 4'h2);
    drive(4'h0, 6, 1, 1'b1, 4'h3);
    drive(4'h5, 6, 1, 1'b0, 4'h3);
    drive(4'h0, 6, 1, 1'b0, 4'h3);
    drive(4'ha, 6, 1, 1'b0, 4'h3);
    drain();

    // Display scan with cnt_stable=A, wrap_count=3
    while (an != 2'b01) @(negedge clk);
    wait_an_change(t0);
    check("dig0_an", an, 2'b10);
    check("dig0_seg", seg, 7'b0001000);
    wait_an_change(t1);
    check("dig1_an", an, 2'b01);
    check("dig1_seg", seg, 7'b0110000);
    check("dig0_period", t1 - t0, 16);
    wait_an_change(t2);
    check("dig1_period", t2 - t1, 16);
    check("dig0_again_an", an, 2'b10);

    // Reset mid-filter with 7 pending (stab_cnt=1)
    drive(4'h7, 4, 0, 1'b0, 4'h0);
    rst = 1'b1;
    #1;
    check("midrst_cnt_stable", cnt_stable, 0);
    check("midrst_wrap_count", wrap_count, 0);
    check("midrst_cnt_upd", cnt_upd, 0);
    check("midrst_an", an, 2'b10);
    check("midrst_seg", seg, 7'b1000000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(4'h7, 8, 1, 1'b0, 4'h0);
    drain();
    check("final_cnt_stable", cnt_stable, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
